// File: rtl/fpu_pkg.sv
// Shared encodings, exception bit positions and IEEE-754 single helpers.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package fpu_pkg;

    // Major opcode and format selectors
    localparam logic [5:0] OP_COP1    = 6'b010001;
    localparam logic [4:0] FMT_ARITH  = 5'b10000;
    localparam logic [4:0] FMT_MFC1   = 5'b00000;
    localparam logic [4:0] FMT_MTC1   = 5'b00100;

    // Arithmetic selectors (fmt = FMT_ARITH)
    localparam logic [5:0] FUNCT_ADD  = 6'b000000;
    localparam logic [5:0] FUNCT_SUB  = 6'b000001;
    localparam logic [5:0] FUNCT_MUL  = 6'b000010;
    localparam logic [5:0] FUNCT_ABS  = 6'b000101;
    localparam logic [5:0] FUNCT_NEG  = 6'b000111;
    localparam logic [5:0] FUNCT_ITOF = 6'b100000;
    localparam logic [5:0] FUNCT_FTOI = 6'b100100;

    // Exception vector bit positions
    localparam int EXC_INVALID     = 0;
    localparam int EXC_OVERFLOW    = 1;
    localparam int EXC_UNDERFLOW   = 2;
    localparam int EXC_UNSUPPORTED = 3;

    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    // Packed value plus the range flags raised while packing it
    typedef struct packed {
        logic [31:0] val;
        logic        ovf;
        logic        unf;
    } fp_res_t;

    function automatic logic is_nan(input logic [31:0] f);
        return (f[30:23] == 8'hFF) && (f[22:0] != 23'd0);
    endfunction

    function automatic logic is_inf(input logic [31:0] f);
        return (f[30:23] == 8'hFF) && (f[22:0] == 23'd0);
    endfunction

    // Denormals are replaced by a zero of the same sign before any use
    function automatic logic [31:0] ftz(input logic [31:0] f);
        return (f[30:23] == 8'd0) ? {f[31], 31'd0} : f;
    endfunction

    // Leading-zero count; 32 for an all-zero word
    function automatic logic [5:0] lzc32(input logic [31:0] v);
        logic       found;
        logic [5:0] n;
        found = 1'b0;
        n     = 6'd32;
        for (int i = 31; i >= 0; i--) begin
            if (!found && v[i]) begin
                n     = 6'(31 - i);
                found = 1'b1;
            end
        end
        return n;
    endfunction

    // Round-to-nearest-even and pack. m[26] is the hidden one, m[2] the
    // guard bit, m[1] round, m[0] sticky. exp_in is the biased exponent.
    function automatic fp_res_t round_pack(input logic              sgn,
                                           input logic signed [9:0] exp_in,
                                           input logic [26:0]       m);
        fp_res_t           res;
        logic              up;
        logic [24:0]       r;
        logic signed [9:0] e;
        up = m[2] & (m[3] | m[1] | m[0]);
        r  = {1'b0, m[26:3]} + {24'd0, up};
        e  = exp_in;
        // Mantissa rounded up to 2.0: renormalise (shifted-out bit is zero)
        if (r[24]) begin
            r = r >> 1;
            e = e + 10'sd1;
        end
        res.ovf = 1'b0;
        res.unf = 1'b0;
        if (e >= 10'sd255) begin
            res.val = {sgn, 8'hFF, 23'd0};
            res.ovf = 1'b1;
        end else if (e <= 10'sd0) begin
            res.val = {sgn, 31'd0};
            res.unf = 1'b1;
        end else begin
            res.val = {sgn, e[7:0], r[22:0]};
        end
        return res;
    endfunction

endpackage

// File: rtl/fpu_cmp.sv
// Single-precision equal / less-than compare; denormals count as signed zero.
// Latency: combinational (registered by the parent).
// Backpressure: none.
// Ports: x, y - operands; eq - numerically equal; lt - x < y. NaN clears both.
module fpu_cmp
    import fpu_pkg::*;
(
    input  logic [31:0] x,
    input  logic [31:0] y,
    output logic        eq,
    output logic        lt
);

    logic [31:0] xf;
    logic [31:0] yf;
    logic        any_nan;
    logic        both_zero;

    assign xf        = ftz(x);
    assign yf        = ftz(y);
    assign any_nan   = is_nan(xf) | is_nan(yf);
    assign both_zero = (xf[30:0] == 31'd0) && (yf[30:0] == 31'd0);

    always_comb begin
        eq = 1'b0;
        lt = 1'b0;
        if (!any_nan) begin
            eq = both_zero | (xf == yf);
            if (!both_zero) begin
                if (xf[31] != yf[31]) begin
                    lt = xf[31];
                end else if (!xf[31]) begin
                    lt = xf[30:0] < yf[30:0];
                end else begin
                    // Both negative: larger magnitude is the smaller value
                    lt = xf[30:0] > yf[30:0];
                end
            end
        end
    end

endmodule

// File: rtl/fpu_unit.sv
// Single-precision cop1 unit: moves, add/sub/mul, abs/neg, int<->float, compare.
// Latency: 1 cycle from in_valid to out_valid, one operation per cycle.
// Backpressure: none; results are produced every cycle and cannot be stalled.
// Ports: clk/rstn; in_valid, op, fmt, funct, a, b, cx, cy in;
//        out_valid, result, exception[3:0], eq, lt out (all registered).
module fpu_unit
    import fpu_pkg::*;
(
    input  logic        clk,
    input  logic        rstn,
    input  logic        in_valid,
    input  logic [5:0]  op,
    input  logic [4:0]  fmt,
    input  logic [5:0]  funct,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [31:0] cx,
    input  logic [31:0] cy,
    output logic        out_valid,
    output logic [31:0] result,
    output logic [3:0]  exception,
    output logic        eq,
    output logic        lt
);

    // Flushed operands and their classes
    logic [31:0] af;
    logic [31:0] bf;
    logic        a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;

    assign af     = ftz(a);
    assign bf     = ftz(b);
    assign a_nan  = is_nan(af);
    assign b_nan  = is_nan(bf);
    assign a_inf  = is_inf(af);
    assign b_inf  = is_inf(bf);
    assign a_zero = (af[30:0] == 31'd0);
    assign b_zero = (bf[30:0] == 31'd0);

    // ---------------- add / sub ----------------
    logic              bs;        // sign of b after the subtract flip
    logic              eff_sub;
    logic              swap;
    logic              big_s;
    logic [7:0]        big_e, small_e, d;
    logic [23:0]       big_m, small_m;
    logic [26:0]       big_x, small_x, aligned, norm_add;
    logic              sticky;
    logic [27:0]       sum;
    logic [5:0]        lz_add;
    logic signed [9:0] e_add;
    fp_res_t           pk_add;
    logic [31:0]       add_res;
    logic [3:0]        add_exc;

    always_comb begin
        bs       = bf[31] ^ (funct == FUNCT_SUB);
        eff_sub  = af[31] ^ bs;
        swap     = bf[30:0] > af[30:0];
        big_s    = swap ? bs : af[31];
        big_e    = swap ? bf[30:23] : af[30:23];
        small_e  = swap ? af[30:23] : bf[30:23];
        big_m    = swap ? {bf[30:23] != 8'd0, bf[22:0]} : {af[30:23] != 8'd0, af[22:0]};
        small_m  = swap ? {af[30:23] != 8'd0, af[22:0]} : {bf[30:23] != 8'd0, bf[22:0]};
        d        = big_e - small_e;
        big_x    = {big_m, 3'b000};
        small_x  = {small_m, 3'b000};
        aligned  = '0;
        sticky   = 1'b0;
        lz_add   = '0;
        norm_add = '0;
        e_add    = '0;
        add_res  = '0;
        add_exc  = '0;

        // Align the smaller operand; everything shifted past the round bit
        // collapses into the sticky bit.
        if (d >= 8'd27) begin
            sticky = |small_x;
        end else begin
            aligned = small_x >> d;
            sticky  = |(small_x & ~(27'h7FF_FFFF << d));
        end
        aligned = aligned | {26'd0, sticky};

        // big >= small in magnitude, so the difference never goes negative
        sum = eff_sub ? ({1'b0, big_x} - {1'b0, aligned})
                      : ({1'b0, big_x} + {1'b0, aligned});

        if (sum[27]) begin
            norm_add = {sum[27:2], sum[1] | sum[0]};
            e_add    = $signed({2'b00, big_e}) + 10'sd1;
        end else begin
            lz_add   = lzc32({sum[26:0], 5'b00000});
            norm_add = sum[26:0] << lz_add;
            e_add    = $signed({2'b00, big_e}) - $signed({4'b0000, lz_add});
        end
        pk_add = round_pack(big_s, e_add, norm_add);

        if (a_nan || b_nan || (a_inf && b_inf && eff_sub)) begin
            add_res              = QNAN;
            add_exc[EXC_INVALID] = 1'b1;
        end else if (a_inf) begin
            add_res = af;
        end else if (b_inf) begin
            add_res = {bs, bf[30:0]};
        end else if (sum == 28'd0) begin
            // Exact zero is +0 unless both addends were negative zeros
            add_res = {af[31] & bs, 31'd0};
        end else begin
            add_res                = pk_add.val;
            add_exc[EXC_OVERFLOW]  = pk_add.ovf;
            add_exc[EXC_UNDERFLOW] = pk_add.unf;
        end
    end

    // ---------------- mul ----------------
    logic              mul_s;
    logic [47:0]       prod;
    logic [26:0]       norm_mul;
    logic signed [9:0] e_mul;
    fp_res_t           pk_mul;
    logic [31:0]       mul_res;
    logic [3:0]        mul_exc;

    always_comb begin
        mul_s   = af[31] ^ bf[31];
        prod    = {af[30:23] != 8'd0, af[22:0]} * {bf[30:23] != 8'd0, bf[22:0]};
        e_mul   = $signed({2'b00, af[30:23]}) + $signed({2'b00, bf[30:23]}) - 10'sd127;
        mul_res = '0;
        mul_exc = '0;
        // Product of two 1.x mantissas lies in [1,4): keep 26 bits plus sticky
        if (prod[47]) begin
            norm_mul = {prod[47:22], |prod[21:0]};
            e_mul    = e_mul + 10'sd1;
        end else begin
            norm_mul = {prod[46:21], |prod[20:0]};
        end
        pk_mul = round_pack(mul_s, e_mul, norm_mul);

        if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) begin
            mul_res              = QNAN;
            mul_exc[EXC_INVALID] = 1'b1;
        end else if (a_inf || b_inf) begin
            mul_res = {mul_s, 8'hFF, 23'd0};
        end else if (a_zero || b_zero) begin
            mul_res = {mul_s, 31'd0};
        end else begin
            mul_res                = pk_mul.val;
            mul_exc[EXC_OVERFLOW]  = pk_mul.ovf;
            mul_exc[EXC_UNDERFLOW] = pk_mul.unf;
        end
    end

    // ---------------- itof ----------------
    logic [31:0] int_mag;
    logic [31:0] norm_i;
    logic [5:0]  lz_i;
    fp_res_t     pk_itof;
    logic [31:0] itof_res;
    logic [3:0]  itof_exc;

    always_comb begin
        // Raw a: an integer word has no denormal or NaN encoding
        int_mag  = a[31] ? (~a + 32'd1) : a;
        lz_i     = lzc32(int_mag);
        norm_i   = int_mag << lz_i;
        pk_itof  = round_pack(a[31], 10'sd158 - $signed({4'b0000, lz_i}),
                              {norm_i[31:6], |norm_i[5:0]});
        itof_res = (a == 32'd0) ? 32'd0 : pk_itof.val;
        itof_exc = '0;
        itof_exc[EXC_OVERFLOW]  = pk_itof.ovf;
        itof_exc[EXC_UNDERFLOW] = pk_itof.unf;
    end

    // ---------------- ftoi ----------------
    logic [31:0] f_mag;
    logic [31:0] ftoi_res;
    logic [3:0]  ftoi_exc;

    always_comb begin
        f_mag    = '0;
        ftoi_res = '0;
        ftoi_exc = '0;
        if (af[30:23] >= 8'd158) begin
            // |a| >= 2^31, inf or NaN; only exactly -2^31 is representable
            if (af == 32'hCF00_0000) begin
                ftoi_res = 32'h8000_0000;
            end else begin
                ftoi_res              = af[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
                ftoi_exc[EXC_INVALID] = 1'b1;
            end
        end else if (af[30:23] >= 8'd127) begin
            // Exponent 150 puts the mantissa LSB at 2^0
            if (af[30:23] >= 8'd150) begin
                f_mag = {8'd0, 1'b1, af[22:0]} << (af[30:23] - 8'd150);
            end else begin
                f_mag = {8'd0, 1'b1, af[22:0]} >> (8'd150 - af[30:23]);
            end
            ftoi_res = af[31] ? (~f_mag + 32'd1) : f_mag;
        end
    end

    // ---------------- operation select ----------------
    logic [31:0] nxt_res;
    logic [3:0]  nxt_exc;
    logic        cmp_eq;
    logic        cmp_lt;

    always_comb begin
        nxt_res = '0;
        nxt_exc = '0;
        nxt_exc[EXC_UNSUPPORTED] = 1'b1;
        if (op == OP_COP1) begin
            unique case (fmt)
                FMT_MFC1: begin
                    nxt_res = a;
                    nxt_exc = '0;
                end
                FMT_MTC1: begin
                    nxt_res = b;
                    nxt_exc = '0;
                end
                FMT_ARITH: begin
                    unique case (funct)
                        FUNCT_ADD, FUNCT_SUB: begin
                            nxt_res = add_res;
                            nxt_exc = add_exc;
                        end
                        FUNCT_MUL: begin
                            nxt_res = mul_res;
                            nxt_exc = mul_exc;
                        end
                        FUNCT_ABS, FUNCT_NEG: begin
                            nxt_exc = '0;
                            if (a_nan) begin
                                nxt_res              = QNAN;
                                nxt_exc[EXC_INVALID] = 1'b1;
                            end else if (funct == FUNCT_ABS) begin
                                nxt_res = {1'b0, af[30:0]};
                            end else begin
                                nxt_res = {~af[31], af[30:0]};
                            end
                        end
                        FUNCT_ITOF: begin
                            nxt_res = itof_res;
                            nxt_exc = itof_exc;
                        end
                        FUNCT_FTOI: begin
                            nxt_res = ftoi_res;
                            nxt_exc = ftoi_exc;
                        end
                        default: ;
                    endcase
                end
                default: ;
            endcase
        end
    end

    fpu_cmp u_cmp (
        .x  (cx),
        .y  (cy),
        .eq (cmp_eq),
        .lt (cmp_lt)
    );

    // Outputs hold their last values through idle cycles
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            out_valid <= 1'b0;
            result    <= '0;
            exception <= '0;
            eq        <= 1'b0;
            lt        <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                result    <= nxt_res;
                exception <= nxt_exc;
                eq        <= cmp_eq;
                lt        <= cmp_lt;
            end
        end
    end

endmodule

// File: tb/tb_fpu_unit.sv
// Directed self-checking bench for fpu_unit with an in-order scoreboard.
// Latency: expects every accepted operation one clock after it is driven.
// Backpressure: none; operations are issued back to back.
module tb_fpu_unit;

    logic        clk = 1'b0;
    logic        rstn;
    logic        in_valid;
    logic [5:0]  op;
    logic [4:0]  fmt;
    logic [5:0]  funct;
    logic [31:0] a, b, cx, cy;
    logic        out_valid;
    logic [31:0] result;
    logic [3:0]  exception;
    logic        eq, lt;

    typedef struct {
        string       tag;
        logic [31:0] res;
        logic [3:0]  exc;
        logic        eq;
        logic        lt;
    } exp_t;

    exp_t sb[$];
    exp_t cur;
    int   n_checks = 0;
    int   n_fail   = 0;

    fpu_unit dut (
        .clk       (clk),
        .rstn      (rstn),
        .in_valid  (in_valid),
        .op        (op),
        .fmt       (fmt),
        .funct     (funct),
        .a         (a),
        .b         (b),
        .cx        (cx),
        .cy        (cy),
        .out_valid (out_valid),
        .result    (result),
        .exception (exception),
        .eq        (eq),
        .lt        (lt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
        n_checks++;
        assert (obs === req) else begin
            n_fail++;
            $error("FAIL %s: observed %h required %h", tag, obs, req);
        end
    endtask

    // Drive one operation for one cycle and record what it must produce
    task automatic issue(input string tag, input logic [5:0] i_op, input logic [4:0] i_fmt,
                         input logic [5:0] i_funct, input logic [31:0] i_a, input logic [31:0] i_b,
                         input logic [31:0] i_cx, input logic [31:0] i_cy,
                         input logic [31:0] e_res, input logic [3:0] e_exc,
                         input logic e_eq, input logic e_lt);
        exp_t e;
        in_valid = 1'b1;
        op = i_op; fmt = i_fmt; funct = i_funct;
        a = i_a; b = i_b; cx = i_cx; cy = i_cy;
        e.tag = tag; e.res = e_res; e.exc = e_exc; e.eq = e_eq; e.lt = e_lt;
        sb.push_back(e);
        @(negedge clk);
    endtask

    task automatic arith(input string tag, input logic [5:0] i_funct, input logic [31:0] i_a,
                         input logic [31:0] i_b, input logic [31:0] e_res, input logic [3:0] e_exc);
        issue(tag, 6'b010001, 5'b10000, i_funct, i_a, i_b, 32'h0, 32'h0, e_res, e_exc, 1'b1, 1'b0);
    endtask

    task automatic cmp(input string tag, input logic [31:0] i_cx, input logic [31:0] i_cy,
                       input logic e_eq, input logic e_lt);
        issue(tag, 6'b010001, 5'b00000, 6'h00, 32'h0, 32'h0, i_cx, i_cy, 32'h0, 4'h0, e_eq, e_lt);
    endtask

    // Scoreboard: every valid output must match the oldest pending operation
    always @(negedge clk) begin
        if (out_valid === 1'b1) begin
            n_checks++;
            assert (sb.size() > 0) else begin
                n_fail++;
                $error("FAIL spurious_output: observed out_valid=1 required no pending operation");
            end
            if (sb.size() > 0) begin
                cur = sb.pop_front();
                chk({cur.tag, "/result"},    result,            cur.res);
                chk({cur.tag, "/exception"}, {28'd0, exception}, {28'd0, cur.exc});
                chk({cur.tag, "/eq"},        {31'd0, eq},       {31'd0, cur.eq});
                chk({cur.tag, "/lt"},        {31'd0, lt},       {31'd0, cur.lt});
            end
        end
    end

    initial begin
        rstn = 1'b0; in_valid = 1'b0;
        op = '0; fmt = '0; funct = '0; a = '0; b = '0; cx = '0; cy = '0;
        repeat (2) @(negedge clk);
        chk("reset/out_valid", {31'd0, out_valid}, 32'd0);
        chk("reset/result",    result,             32'd0);
        chk("reset/exception", {28'd0, exception}, 32'd0);
        chk("reset/eq",        {31'd0, eq},        32'd0);
        chk("reset/lt",        {31'd0, lt},        32'd0);

        rstn = 1'b1;
        @(negedge clk);
        chk("idle_after_reset/out_valid", {31'd0, out_valid}, 32'd0);

        issue("mfc1", 6'b010001, 5'b00000, 6'h00, 32'h3F80_0000, 32'h0, 32'h0, 32'h0,
              32'h3F80_0000, 4'h0, 1'b1, 1'b0);
        chk("latency/out_valid", {31'd0, out_valid}, 32'd1);
        issue("mtc1", 6'b010001, 5'b00100, 6'h00, 32'h0, 32'hDEAD_BEEF, 32'h0, 32'h0,
              32'hDEAD_BEEF, 4'h0, 1'b1, 1'b0);

        arith("add",          6'h00, 32'h3FC0_0000, 32'h4010_0000, 32'h4070_0000, 4'h0);
        arith("sub_zero",     6'h01, 32'h3FC0_0000, 32'h3FC0_0000, 32'h0000_0000, 4'h0);
        arith("add_negzero",  6'h00, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 4'h0);
        arith("add_tie_even", 6'h00, 32'h3F80_0000, 32'h3380_0000, 32'h3F80_0000, 4'h0);
        arith("add_tie_up",   6'h00, 32'h3F80_0001, 32'h3380_0000, 32'h3F80_0002, 4'h0);
        arith("add_denorm",   6'h00, 32'h0000_0001, 32'h3F80_0000, 32'h3F80_0000, 4'h0);
        arith("add_nan",      6'h00, 32'h7F80_0001, 32'h3F80_0000, 32'h7FC0_0000, 4'b0001);
        arith("sub_inf_inf",  6'h01, 32'h7F80_0000, 32'h7F80_0000, 32'h7FC0_0000, 4'b0001);
        arith("mul_ovf",      6'h02, 32'h7F00_0000, 32'h7F00_0000, 32'h7F80_0000, 4'b0010);
        arith("mul",          6'h02, 32'h4000_0000, 32'h4040_0000, 32'h40C0_0000, 4'h0);
        arith("mul_0_inf",    6'h02, 32'h0000_0000, 32'h7F80_0000, 32'h7FC0_0000, 4'b0001);
        arith("mul_unf",      6'h02, 32'h0080_0000, 32'h3F00_0000, 32'h0000_0000, 4'b0100);
        arith("itof",         6'h20, 32'hFFFF_FFFD, 32'h0,         32'hC040_0000, 4'h0);
        arith("ftoi",         6'h24, 32'hC060_0000, 32'h0,         32'hFFFF_FFFD, 4'h0);
        arith("ftoi_sat",     6'h24, 32'h4F80_0000, 32'h0,         32'h7FFF_FFFF, 4'b0001);
        arith("ftoi_nan_neg", 6'h24, 32'hFFC0_0000, 32'h0,         32'h8000_0000, 4'b0001);
        arith("abs",          6'h05, 32'hBF80_0000, 32'h0,         32'h3F80_0000, 4'h0);
        arith("unsup_funct",  6'h3F, 32'h3F80_0000, 32'h3F80_0000, 32'h0000_0000, 4'b1000);
        issue("unsup_op",  6'b000000, 5'b00000, 6'h00, 32'h1234_5678, 32'h0,
              32'hBF80_0000, 32'h3F80_0000, 32'h0, 4'b1000, 1'b0, 1'b1);
        issue("unsup_fmt", 6'b010001, 5'b00001, 6'h00, 32'h1234_5678, 32'h0,
              32'h0, 32'h0, 32'h0, 4'b1000, 1'b1, 1'b0);

        cmp("cmp_zeros",   32'h8000_0000, 32'h0000_0000, 1'b1, 1'b0);
        cmp("cmp_neg_pos", 32'hBF80_0000, 32'h3F80_0000, 1'b0, 1'b1);
        cmp("cmp_nan",     32'h7FC0_0000, 32'h3F80_0000, 1'b0, 1'b0);
        cmp("cmp_pos_neg", 32'h3F80_0000, 32'hBF80_0000, 1'b0, 1'b0);
        cmp("cmp_neg_neg", 32'hC000_0000, 32'hBF80_0000, 1'b0, 1'b1);

        arith("neg",          6'h07, 32'h3F80_0000, 32'h0,         32'hBF80_0000, 4'h0);

        // Idle cycle: out_valid drops, data outputs hold
        in_valid = 1'b0;
        a = 32'h4000_0000;
        @(negedge clk);
        chk("hold/out_valid", {31'd0, out_valid}, 32'd0);
        chk("hold/result",    result,             32'hBF80_0000);
        chk("hold/exception", {28'd0, exception}, 32'd0);

        // Asynchronous reset mid-cycle with an operation presented
        #2;
        rstn = 1'b0;
        in_valid = 1'b1; op = 6'b010001; fmt = 5'b00000; a = 32'h1111_1111;
        #1;
        chk("async_reset/result",   result,             32'd0);
        chk("async_reset/out_valid", {31'd0, out_valid}, 32'd0);
        chk("async_reset/eq",       {31'd0, eq},        32'd0);
        @(negedge clk);
        chk("in_reset/out_valid", {31'd0, out_valid}, 32'd0);
        chk("in_reset/result",    result,             32'd0);
        rstn = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("after_release/out_valid", {31'd0, out_valid}, 32'd0);

        issue("post_reset", 6'b010001, 5'b00000, 6'h00, 32'h4049_0FDB, 32'h0, 32'h0, 32'h0,
              32'h4049_0FDB, 4'h0, 1'b1, 1'b0);
        chk("post_reset/out_valid", {31'd0, out_valid}, 32'd1);
        in_valid = 1'b0;

        for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
        chk("drain/pending", sb.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
